// File: rtl/seg7_apb_mux_ctrl.sv
// APB3 slave driving a time-multiplexed, common-anode 7-segment display bank.
// Register file, PWM-dimmed scan engine and registered, glitch-free pin drivers.
module seg7_apb_mux_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                pclk_i,
  input  logic                preset_i,
  input  logic [31:0]         paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         pwdata_i,
  input  logic [3:0]          pstrb_i,
  output logic                pready_o,
  output logic [31:0]         prdata_o,
  output logic                pslverr_o,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [N_DIGITS-1:0] an_o
);

  localparam int CW   = $clog2(REFRESH_DIV);
  localparam int STEP = REFRESH_DIV / 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(N_DIGITS - 1);

  localparam logic [2:0] A_DIGITS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_DPMASK = 3'd2;
  localparam logic [2:0] A_BLANK  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  // Architectural registers
  logic [4*N_DIGITS-1:0] r_digits;
  logic                  r_en;
  logic [3:0]            r_bright;
  logic [N_DIGITS-1:0]   r_dpmask;
  logic [N_DIGITS-1:0]   r_blank;

  // Scan engine and registered pin drivers
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_idx;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  // APB decode
  logic        w_access;
  logic [4:0]  w_addr;
  logic        w_err;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_digits;
  logic        w_wr_ctrl;
  logic        w_wr_dpmask;
  logic        w_wr_blank;
  logic [31:0] w_reg_img;
  logic [31:0] w_wdata;
  logic        w_en_next;

  // Display datapath
  logic [31:0] w_digits32;
  logic [7:0]  w_dp8;
  logic [7:0]  w_blank8;
  logic [7:0]  w_onehot;
  logic [3:0]  w_digit;
  logic [CW:0] w_thresh;
  logic        w_lit;
  logic        w_unused;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_unused = &{1'b0, paddr_i[31:5]};

  assign w_access = psel_i & penable_i;
  assign w_addr   = paddr_i[4:0];
  assign w_err    = w_access & ((w_addr[1:0] != 2'b00) || (w_addr > 5'h10) ||
                                (pwrite_i && (w_addr == 5'h10)));
  assign w_wr     = w_access & pwrite_i & ~w_err;
  assign w_rd     = w_access & ~pwrite_i & ~w_err;

  assign w_wr_digits = w_wr && (w_addr[4:2] == A_DIGITS);
  assign w_wr_ctrl   = w_wr && (w_addr[4:2] == A_CTRL);
  assign w_wr_dpmask = w_wr && (w_addr[4:2] == A_DPMASK);
  assign w_wr_blank  = w_wr && (w_addr[4:2] == A_BLANK);

  assign w_digits32 = 32'(r_digits);
  assign w_dp8      = 8'(r_dpmask);
  assign w_blank8   = 8'(r_blank);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_reg_img = '0;
    case (w_addr[4:2])
      A_DIGITS: w_reg_img = w_digits32;
      A_CTRL:   w_reg_img = {20'd0, r_bright, 7'd0, r_en};
      A_DPMASK: w_reg_img = 32'(r_dpmask);
      A_BLANK:  w_reg_img = 32'(r_blank);
      A_STATUS: w_reg_img = {23'd0, r_en, 5'd0, r_idx};
      default:  w_reg_img = '0;
    endcase
  end

  // Byte lanes not strobed keep the register's current contents.
  always_comb begin
    w_wdata = w_reg_img;
    for (int b = 0; b < 4; b++) begin
      if (pstrb_i[b]) w_wdata[b*8 +: 8] = pwdata_i[b*8 +: 8];
    end
  end

  assign w_en_next = w_wr_ctrl ? w_wdata[0] : r_en;

  assign pready_o  = 1'b1;
  assign pslverr_o = w_err;
  assign prdata_o  = w_rd ? w_reg_img : 32'd0;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_digits <= '0;
      r_en     <= 1'b0;
      r_bright <= 4'hF;
      r_dpmask <= '0;
      r_blank  <= '0;
    end else begin
      if (w_wr_digits) r_digits <= w_wdata[4*N_DIGITS-1:0];
      if (w_wr_ctrl) begin
        r_en     <= w_wdata[0];
        r_bright <= w_wdata[11:8];
      end
      if (w_wr_dpmask) r_dpmask <= w_wdata[N_DIGITS-1:0];
      if (w_wr_blank)  r_blank  <= w_wdata[N_DIGITS-1:0];
    end
  end

  // A disabling write on the terminal edge must clear, not advance, the scan.
  always_ff @(posedge pclk_i) begin
    if (preset_i || !w_en_next) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_thresh = (CW+1)'((32'(r_bright) + 32'd1) * 32'(STEP));
  assign w_lit    = r_en && ({1'b0, r_cnt} < w_thresh) && !w_blank8[r_idx];
  assign w_onehot = 8'd1 << r_idx;
  assign w_digit  = w_digits32[{r_idx, 2'b00} +: 4];

  // Anodes and segments share one register stage so they switch on the same edge.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~w_onehot[N_DIGITS-1:0];
      r_seg <= hex7(w_digit);
      r_dp  <= ~w_dp8[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end
  end

  assign an_o  = r_an;
  assign seg_o = r_seg;
  assign dp_o  = r_dp;

endmodule

// File: tb/tb_seg7_apb_mux_ctrl.sv
// Self-checking bench for seg7_apb_mux_ctrl (4 digits, 16-cycle slots).
// Register and display expectations come from a register-image model and scan-time arithmetic.
module tb_seg7_apb_mux_ctrl;

  localparam int N  = 4;
  localparam int RD = 16;

  localparam logic [31:0] MASK_DIG  = 32'h0000_FFFF;
  localparam logic [31:0] MASK_CTRL = 32'h0000_0F01;
  localparam logic [31:0] MASK_BITS = 32'h0000_000F;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic [31:0]   paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic          pready;
  logic [31:0]   prdata;
  logic          pslverr;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_digits, m_ctrl, m_dp, m_blank, m_status;

  logic [6:0] hex7_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_apb_mux_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .pclk_i(pclk), .preset_i(preset), .paddr_i(paddr), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
    .seg_o(seg), .dp_o(dp), .an_o(an)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_digits = 32'd0; m_ctrl = 32'h0000_0F00; m_dp = 32'd0; m_blank = 32'd0; m_status = 32'd0;
  endfunction

  function automatic logic exp_err(input logic wr, input logic [31:0] a);
    int off;
    off = int'(a[4:0]);
    return (off % 4 != 0) || (off > 16) || (wr && off == 16);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (int'(a[4:0]))
      0:  return m_digits;
      4:  return m_ctrl;
      8:  return m_dp;
      12: return m_blank;
      16: return m_status;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] lm;
    lm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    case (int'(a[4:0]))
      0:  m_digits = ((m_digits & ~lm) | (d & lm)) & MASK_DIG;
      4:  m_ctrl   = ((m_ctrl   & ~lm) | (d & lm)) & MASK_CTRL;
      8:  m_dp     = ((m_dp     & ~lm) | (d & lm)) & MASK_BITS;
      12: m_blank  = ((m_blank  & ~lm) | (d & lm)) & MASK_BITS;
      default: ;
    endcase
  endfunction

  // ---------------- APB driver ----------------
  // Returns on the falling edge right after the commit edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    #1;
    n_checks++;
    if (pslverr !== 1'b0 || prdata !== 32'd0) begin
      n_fail++;
      $display("FAIL setup_idle addr=%h got pslverr=%b prdata=%h exp 0/0", a, pslverr, prdata);
    end
    @(negedge pclk);
    penable = 1'b1;
    #1;
    rd = prdata; err = pslverr;
    @(posedge pclk);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic err, e;
    e = exp_err(1'b1, a);
    apb_xfer(1'b1, a, d, s, rd, err);
    n_checks++;
    if (err !== e) begin
      n_fail++;
      $display("FAIL wr_pslverr addr=%h got=%b exp=%b", a, err, e);
    end
    if (!e) model_apply(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] rd, exp;
    logic err, e;
    e   = exp_err(1'b0, a);
    exp = e ? 32'd0 : model_read(a);
    apb_xfer(1'b0, a, 32'd0, 4'h0, rd, err);
    n_checks++;
    if (err !== e) begin
      n_fail++;
      $display("FAIL rd_pslverr addr=%h got=%b exp=%b", a, err, e);
    end
    n_checks++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL rd_data addr=%h got=%h exp=%h", a, rd, exp);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 5; i++) do_read(32'(i * 4));
  endtask

  task automatic check_dark(input string tag);
    n_checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL %s dark: got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", tag, an, seg, dp);
    end
  endtask

  // Call right after the enabling write returns. Cycle p after enable is scan
  // position p; the pins show position p-1 on the following cycle.
  task automatic observe(input int cycles, input string tag);
    int p, cnt, idx, bright;
    logic lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    check_dark({tag, "_k0"});
    bright = int'(m_ctrl[11:8]);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge pclk);
      p   = k - 1;
      cnt = p % RD;
      idx = (p / RD) % N;
      lit = (cnt < (bright + 1) * (RD / 16)) && !m_blank[idx];
      e_an  = lit ? ~(4'd1 << idx) : 4'hF;
      e_seg = lit ? hex7_tab[(m_digits >> (4 * idx)) & 32'hF] : 7'h7F;
      e_dp  = lit ? ~m_dp[idx] : 1'b1;
      n_checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL %s k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 tag, k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    // STATUS access phase lands two cycles after the last observed one.
    m_status = {23'd0, 1'b1, 5'd0, 3'((((cycles + 2) / RD) % N))};
    do_read(32'h10);
  endtask

  task automatic disable_scan(input string tag);
    do_write(32'h04, {20'd0, m_ctrl[11:8], 8'h00}, 4'hF);
    m_status = 32'd0;
    @(negedge pclk);
    check_dark(tag);
    do_read(32'h10);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    check_dark("reset");
    n_checks++;
    if (pready !== 1'b1) begin
      n_fail++;
      $display("FAIL pready got=%b exp=1", pready);
    end
    read_all();
  endtask

  task automatic test_scan_directed();
    do_write(32'h00, 32'h0000_F910, 4'hF);
    do_write(32'h04, 32'h0000_0F01, 4'hF);
    observe(2 * N * RD + 4, "scan_dir");
    disable_scan("scan_dir_off");
  endtask

  task automatic test_pwm_blank_dp();
    do_write(32'h0C, 32'h2, 4'hF);
    do_write(32'h08, 32'h4, 4'hF);
    do_write(32'h04, 32'h0000_0301, 4'hF);
    observe(2 * N * RD, "pwm");
    disable_scan("pwm_off");
    do_write(32'h0C, 32'h0, 4'hF);
    do_write(32'h08, 32'h0, 4'hF);
  endtask

  task automatic test_random_scan();
    logic [31:0] c;
    for (int r = 0; r < 4; r++) begin
      do_write(32'h00, $urandom, 4'hF);
      do_write(32'h08, $urandom, 4'hF);
      do_write(32'h0C, $urandom & 32'h7, 4'hF);
      c = $urandom;
      c[0] = 1'b1;
      do_write(32'h04, c, 4'hF);
      observe(N * RD + int'($urandom_range(0, 40)), "scan_rnd");
      disable_scan("scan_rnd_off");
    end
    do_write(32'h0C, 32'h0, 4'hF);
  endtask

  task automatic test_strobes();
    logic [31:0] a, d;
    do_write(32'h00, 32'h0, 4'hF);
    do_write(32'h00, 32'hFFFF_FFFF, 4'b0010);
    do_read(32'h00);
    for (int i = 0; i < 12; i++) begin
      a = 32'($urandom_range(0, 3) * 4);
      d = $urandom & 32'hFFFF_FFFE;
      do_write(a, d, 4'($urandom));
      do_read(a);
    end
    read_all();
  endtask

  task automatic test_errors();
    logic [31:0] a, d;
    do_write(32'h00, 32'h0000_1234, 4'hF);
    do_read(32'h02);
    do_read(32'h14);
    do_write(32'h02, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h14, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h1D, 32'hFFFF_FFFF, 4'hF);
    do_read(32'h11);
    do_read(32'hFFFF_FFE4);
    read_all();
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      d = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 1) == 1) do_write(a, d, 4'($urandom));
      else do_read(a);
    end
    read_all();
  endtask

  task automatic test_reset_midflight();
    do_write(32'h00, 32'h0000_1234, 4'hF);
    do_write(32'h04, 32'h0000_0F01, 4'hF);
    repeat (21) @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0000_ABCD; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    preset  = 1'b1;
    @(negedge pclk);
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_reset();
    check_dark("rst_mid");
    @(negedge pclk);
    check_dark("rst_mid_hold");
    read_all();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_directed();
    test_pwm_blank_dp();
    test_random_scan();
    test_strobes();
    test_errors();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
